// File: rtl/promotion_menu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : promotion_menu_ctrl_pkg
//  Purpose  : Shared types and constants for the pawn-promotion menu block.
//             Holds the FSM state encoding, the piece codes reported on the
//             result handshake, and the sprite-row thresholds that split the
//             menu sprite into four option bands.
//  Revision : 1.0  initial release
// ============================================================================
package promotion_menu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPEN   = 3'd1,
    ST_SELECT = 3'd2,
    ST_COMMIT = 3'd3,
    ST_CLOSE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PIECE_QUEEN  = 2'd0,
    PIECE_ROOK   = 2'd1,
    PIECE_BISHOP = 2'd2,
    PIECE_KNIGHT = 2'd3
  } piece_e;

  // First sprite row (ly) of option bands 1, 2 and 3.
  localparam logic [9:0] BAND1_LY = 10'd62;
  localparam logic [9:0] BAND2_LY = 10'd124;
  localparam logic [9:0] BAND3_LY = 10'd186;

endpackage
`default_nettype wire

// File: rtl/promo_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : promo_addr_gen
//  Purpose  : Pixel-side logic of the promotion menu. Tests whether the
//             current pixel falls inside the sprite window, forms the sprite
//             ROM address and decides whether the pixel sits in the displayed
//             selected option band. All outputs are registered (1 cycle).
//  Ports    : vga_clk, reset_n        clock / async active-low reset
//             menu_active_i           menu currently visible
//             shown_sel_i[1:0]        option band to highlight this frame
//             draw_x_i, draw_y_i      current pixel coordinates
//             overlay_en_o            pixel shows the sprite
//             rom_address_o[13:0]     sprite ROM address (0 outside window)
//             highlight_o             pixel in the highlighted band
//  Revision : 1.0  initial release
// ============================================================================
module promo_addr_gen
  import promotion_menu_ctrl_pkg::*;
#(
  parameter int ORIGIN_X = 292,
  parameter int ORIGIN_Y = 116,
  parameter int SPR_W    = 55,
  parameter int SPR_H    = 247
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        menu_active_i,
  input  logic [1:0]  shown_sel_i,
  input  logic [9:0]  draw_x_i,
  input  logic [9:0]  draw_y_i,
  output logic        overlay_en_o,
  output logic [13:0] rom_address_o,
  output logic        highlight_o
);

  // Bounds are one bit wider than the coordinates so the exclusive upper
  // edge cannot wrap for windows touching the screen limit.
  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + SPR_W);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + SPR_H);
  localparam logic [9:0]  X0   = 10'(ORIGIN_X);
  localparam logic [9:0]  Y0   = 10'(ORIGIN_Y);

  logic        w_hit;
  logic [9:0]  w_lx;
  logic [9:0]  w_ly;
  logic [13:0] w_lx14;
  logic [13:0] w_ly14;
  logic [13:0] w_addr;
  logic [1:0]  w_band;

  assign w_hit = ({1'b0, draw_x_i} >= X_LO) && ({1'b0, draw_x_i} < X_HI) &&
                 ({1'b0, draw_y_i} >= Y_LO) && ({1'b0, draw_y_i} < Y_HI);

  assign w_lx   = draw_x_i - X0;
  assign w_ly   = draw_y_i - Y0;
  assign w_lx14 = {4'd0, w_lx};
  assign w_ly14 = {4'd0, w_ly};

  // ly*55 = ly*64 - ly*8 - ly. Out-of-window garbage is masked below.
  assign w_addr = (w_ly14 << 6) - (w_ly14 << 3) - w_ly14 + w_lx14;

  always_comb begin
    w_band = 2'd3;
    if (w_ly < BAND1_LY)      w_band = 2'd0;
    else if (w_ly < BAND2_LY) w_band = 2'd1;
    else if (w_ly < BAND3_LY) w_band = 2'd2;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      overlay_en_o  <= 1'b0;
      rom_address_o <= 14'd0;
      highlight_o   <= 1'b0;
    end else begin
      overlay_en_o  <= menu_active_i & w_hit;
      rom_address_o <= w_hit ? w_addr : 14'd0;
      highlight_o   <= menu_active_i & w_hit & (w_band == shown_sel_i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/promotion_menu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : promotion_menu_ctrl
//  Purpose  : Pawn-promotion menu controller. Opens a sprite menu on request,
//             lets the player cycle through queen/rook/bishop/knight with
//             up/down keys, commits the choice on enter via a valid/ready
//             handshake, and closes the menu at the next frame boundary.
//  Ports    : vga_clk, reset_n                clock / async active-low reset
//             promo_req                       promotion requested (level)
//             key_up, key_down, key_enter     synchronised key levels
//             frame_start                     vertical-blank start pulse
//             DrawX, DrawY                    current pixel coordinates
//             overlay_en, rom_address,
//             highlight                       registered pixel outputs
//             piece_valid, piece_sel,
//             piece_ready                     result handshake
//             busy                            session in progress
//  Revision : 1.0  initial release
// ============================================================================
module promotion_menu_ctrl
  import promotion_menu_ctrl_pkg::*;
#(
  parameter int ORIGIN_X = 292,
  parameter int ORIGIN_Y = 116,
  parameter int SPR_W    = 55,
  parameter int SPR_H    = 247
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        promo_req,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_enter,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        overlay_en,
  output logic [13:0] rom_address,
  output logic        highlight,
  output logic        piece_valid,
  output logic [1:0]  piece_sel,
  input  logic        piece_ready,
  output logic        busy
);

  state_e     state_q;
  piece_e     sel_q;
  piece_e     piece_sel_q;
  logic [1:0] shown_sel_q;
  logic       menu_active_q;
  logic       piece_valid_q;
  logic       key_up_q;
  logic       key_down_q;
  logic       key_enter_q;

  logic w_up_rise;
  logic w_down_rise;
  logic w_enter_rise;

  assign w_up_rise    = key_up    & ~key_up_q;
  assign w_down_rise  = key_down  & ~key_down_q;
  assign w_enter_rise = key_enter & ~key_enter_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= PIECE_QUEEN;
      piece_sel_q   <= PIECE_QUEEN;
      shown_sel_q   <= 2'd0;
      menu_active_q <= 1'b0;
      piece_valid_q <= 1'b0;
      key_up_q      <= 1'b0;
      key_down_q    <= 1'b0;
      key_enter_q   <= 1'b0;
    end else begin
      key_up_q    <= key_up;
      key_down_q  <= key_down;
      key_enter_q <= key_enter;

      // Latched only at frame boundaries so the highlight band is stable
      // for a whole frame.
      if (frame_start) shown_sel_q <= sel_q;

      case (state_q)
        ST_IDLE: begin
          if (promo_req) begin
            state_q <= ST_OPEN;
            sel_q   <= PIECE_QUEEN;
          end
        end
        ST_OPEN: begin
          if (frame_start) begin
            state_q       <= ST_SELECT;
            menu_active_q <= 1'b1;
          end
        end
        ST_SELECT: begin
          // Enter wins over navigation; opposing up/down edges cancel.
          if (w_enter_rise) begin
            state_q       <= ST_COMMIT;
            piece_sel_q   <= sel_q;
            piece_valid_q <= 1'b1;
          end else if (w_up_rise && !w_down_rise) begin
            sel_q <= piece_e'(sel_q - 2'd1);
          end else if (w_down_rise && !w_up_rise) begin
            sel_q <= piece_e'(sel_q + 2'd1);
          end
        end
        ST_COMMIT: begin
          if (piece_ready) begin
            state_q       <= ST_CLOSE;
            piece_valid_q <= 1'b0;
          end
        end
        ST_CLOSE: begin
          if (frame_start) begin
            state_q       <= ST_IDLE;
            menu_active_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign piece_valid = piece_valid_q;
  assign piece_sel   = piece_sel_q;
  assign busy        = (state_q != ST_IDLE);

  promo_addr_gen #(
    .ORIGIN_X (ORIGIN_X),
    .ORIGIN_Y (ORIGIN_Y),
    .SPR_W    (SPR_W),
    .SPR_H    (SPR_H)
  ) u_addr_gen (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .menu_active_i (menu_active_q),
    .shown_sel_i   (shown_sel_q),
    .draw_x_i      (DrawX),
    .draw_y_i      (DrawY),
    .overlay_en_o  (overlay_en),
    .rom_address_o (rom_address),
    .highlight_o   (highlight)
  );

endmodule
`default_nettype wire

// File: tb/tb_promotion_menu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_promotion_menu_ctrl
//  Purpose  : Self-checking bench for promotion_menu_ctrl. A table of pixel
//             vectors exercises the window, address and band logic; directed
//             sequences cover navigation, the commit handshake, menu close
//             and reset during a session.
//  Revision : 1.0  initial release
// ============================================================================
module tb_promotion_menu_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic        promo_req, key_up, key_down, key_enter, frame_start;
  logic [9:0]  DrawX, DrawY;
  logic        overlay_en, highlight, piece_valid, piece_ready, busy;
  logic [13:0] rom_address;
  logic [1:0]  piece_sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 vga_clk = ~vga_clk;

  promotion_menu_ctrl dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .promo_req   (promo_req),
    .key_up      (key_up),
    .key_down    (key_down),
    .key_enter   (key_enter),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .overlay_en  (overlay_en),
    .rom_address (rom_address),
    .highlight   (highlight),
    .piece_valid (piece_valid),
    .piece_sel   (piece_sel),
    .piece_ready (piece_ready),
    .busy        (busy)
  );

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ov;
    logic [13:0] addr;
    logic        hl;
  } pix_t;

  pix_t vec [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // One-cycle key press followed by one cycle released.
  task automatic press(input logic u, input logic d, input logic e);
    key_up = u; key_down = d; key_enter = e;
    step();
    key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0;
    step();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    // Sprite window 292..346 x 116..362, highlight band 0 shown.
    vec[0] = '{x:10'd292, y:10'd116, ov:1'b1, addr:14'd0,     hl:1'b1};
    vec[1] = '{x:10'd346, y:10'd116, ov:1'b1, addr:14'd54,    hl:1'b1};
    vec[2] = '{x:10'd347, y:10'd116, ov:1'b0, addr:14'd0,     hl:1'b0};
    vec[3] = '{x:10'd291, y:10'd116, ov:1'b0, addr:14'd0,     hl:1'b0};
    vec[4] = '{x:10'd292, y:10'd362, ov:1'b1, addr:14'd13530, hl:1'b0};
    vec[5] = '{x:10'd346, y:10'd362, ov:1'b1, addr:14'd13584, hl:1'b0};
    vec[6] = '{x:10'd292, y:10'd363, ov:1'b0, addr:14'd0,     hl:1'b0};
    vec[7] = '{x:10'd300, y:10'd177, ov:1'b1, addr:14'd3363,  hl:1'b1};
    vec[8] = '{x:10'd300, y:10'd178, ov:1'b1, addr:14'd3418,  hl:1'b0};
    vec[9] = '{x:10'd300, y:10'd115, ov:1'b0, addr:14'd0,     hl:1'b0};

    reset_n = 1'b0;
    promo_req = 1'b0; key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0;
    frame_start = 1'b0; piece_ready = 1'b0;
    DrawX = 10'd292; DrawY = 10'd116;
    step(); step();
    chk("rst_busy",    32'(busy),        32'd0);
    chk("rst_valid",   32'(piece_valid), 32'd0);
    chk("rst_sel",     32'(piece_sel),   32'd0);
    chk("rst_overlay", 32'(overlay_en),  32'd0);
    chk("rst_addr",    32'(rom_address), 32'd0);
    chk("rst_hl",      32'(highlight),   32'd0);
    reset_n = 1'b1;
    step();

    // Open the menu.
    promo_req = 1'b1;
    step();
    promo_req = 1'b0;
    chk("open_busy", 32'(busy), 32'd1);
    frame();
    step();
    chk("first_overlay", 32'(overlay_en),  32'd1);
    chk("first_addr",    32'(rom_address), 32'd0);
    chk("first_hl",      32'(highlight),   32'd1);

    for (int i = 0; i < 10; i++) begin
      DrawX = vec[i].x; DrawY = vec[i].y;
      step();
      chk($sformatf("vec%0d_overlay", i), 32'(overlay_en),  32'(vec[i].ov));
      chk($sformatf("vec%0d_addr", i),    32'(rom_address), 32'(vec[i].addr));
      chk($sformatf("vec%0d_hl", i),      32'(highlight),   32'(vec[i].hl));
    end

    // Down twice -> bishop; highlight follows only after frame_start.
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    DrawX = 10'd300; DrawY = 10'd250;
    frame();
    chk("midframe_hl",   32'(highlight),   32'd0);
    chk("band2_addr0",   32'(rom_address), 32'd7378);
    step();
    chk("band2_hl",      32'(highlight),   32'd1);
    chk("band2_addr",    32'(rom_address), 32'd7378);

    // Up twice back to queen, confirmed through band 0 highlight.
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    DrawX = 10'd300; DrawY = 10'd120;
    frame();
    step();
    chk("band0_hl", 32'(highlight), 32'd1);

    // Up from queen wraps to knight; simultaneous up/down is ignored.
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    key_enter = 1'b1;
    step();
    key_enter = 1'b0;
    chk("commit_valid", 32'(piece_valid), 32'd1);
    chk("commit_sel",   32'(piece_sel),   32'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold%0d_valid", i), 32'(piece_valid), 32'd1);
      chk($sformatf("hold%0d_sel", i),   32'(piece_sel),   32'd3);
    end
    piece_ready = 1'b1;
    step();
    piece_ready = 1'b0;
    chk("handshake_valid", 32'(piece_valid), 32'd0);
    chk("close_busy",      32'(busy),        32'd1);
    chk("close_overlay",   32'(overlay_en),  32'd1);
    frame();
    chk("idle_busy", 32'(busy), 32'd0);
    step();
    chk("closed_overlay", 32'(overlay_en), 32'd0);
    DrawX = 10'd291; DrawY = 10'd116;
    step();
    chk("left_edge_overlay", 32'(overlay_en), 32'd0);
    DrawX = 10'd347;
    step();
    chk("right_edge_overlay", 32'(overlay_en), 32'd0);

    // Second session: stray ready, enter beats down, then reset in COMMIT.
    DrawX = 10'd300; DrawY = 10'd120;
    promo_req = 1'b1;
    step();
    promo_req = 1'b0;
    frame();
    piece_ready = 1'b1;
    step();
    piece_ready = 1'b0;
    chk("stray_ready_valid", 32'(piece_valid), 32'd0);
    chk("stray_ready_busy",  32'(busy),        32'd1);
    chk("s2_overlay",        32'(overlay_en),  32'd1);
    press(1'b0, 1'b1, 1'b0);
    key_enter = 1'b1; key_down = 1'b1;
    step();
    key_enter = 1'b0; key_down = 1'b0;
    chk("enter_prio_valid", 32'(piece_valid), 32'd1);
    chk("enter_prio_sel",   32'(piece_sel),   32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid",   32'(piece_valid), 32'd0);
    chk("async_rst_overlay", 32'(overlay_en),  32'd0);
    chk("async_rst_busy",    32'(busy),        32'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d_valid", i), 32'(piece_valid), 32'd0);
    end

    // Level request held high starts a session from idle.
    promo_req = 1'b1;
    step();
    chk("held_req_busy", 32'(busy), 32'd1);
    promo_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/promotion_menu_ctrl.md
PROMOTION_MENU_CTRL -- requirements
Module: promotion_menu_ctrl

Interface
REQ-001 SHALL have parameter ORIGIN_X, default 292, left column of the menu window on screen.
REQ-002 SHALL have parameter ORIGIN_Y, default 116, top row of the menu window on screen.
REQ-003 SHALL have parameters SPR_W, default 55, and SPR_H, default 247, the promotion sprite dimensions in pixels.
REQ-004 SHALL have port vga_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port promo_req  in  1  level from board logic requesting a promotion choice.
REQ-007 SHALL have port key_up, key_down, key_enter  in  1 each  synchronised key levels; the block edge-detects them internally.
REQ-008 SHALL have port frame_start  in  1  one-cycle pulse at the start of vertical blank.
REQ-009 SHALL have port DrawX, DrawY  in  10 each  current pixel coordinates.
REQ-010 SHALL have port overlay_en  out  1  current pixel shows the sprite.
REQ-011 SHALL have port rom_address  out  14  sprite ROM address for the current pixel.
REQ-012 SHALL have port highlight  out  1  current pixel lies in the displayed selected option band.
REQ-013 SHALL have port piece_valid  out  1, piece_sel  out  2 (0 queen, 1 rook, 2 bishop, 3 knight), and piece_ready  in  1: the result handshake.
REQ-014 SHALL have port busy  out  1  FSM not in IDLE.

Function
REQ-015 FSM states SHALL be IDLE, OPEN, SELECT, COMMIT and CLOSE.
REQ-016 IDLE->OPEN on promo_req=1; sel resets to 0 (queen) on this transition.
REQ-017 OPEN->SELECT on frame_start; menu_active is set on that same edge.
REQ-018 In SELECT, a key_up rising edge decrements sel with wrap 0->3, and a key_down rising edge increments sel with wrap 3->0.
REQ-019 Up and down rising edges in the same cycle SHALL be ignored.
REQ-020 shown_sel SHALL copy sel only on frame_start, so highlight never changes mid-frame.
REQ-021 In SELECT, a key_enter rising edge moves the FSM to COMMIT with piece_sel=sel; enter takes priority over a simultaneous up/down edge, and sel does not move in that cycle.
REQ-022 In COMMIT, piece_valid=1 and piece_sel is held stable until piece_valid and piece_ready are both 1 on a clock edge; then COMMIT->CLOSE and piece_valid=0 from the next cycle.
REQ-023 piece_ready while not in COMMIT SHALL be ignored.
REQ-024 CLOSE->IDLE on frame_start; menu_active clears on that same edge.
REQ-025 promo_req outside IDLE SHALL be ignored; promo_req still high on return to IDLE starts a new session.
REQ-026 Window hit SHALL be ORIGIN_X <= DrawX < ORIGIN_X+SPR_W and ORIGIN_Y <= DrawY < ORIGIN_Y+SPR_H.
REQ-027 With lx=DrawX-ORIGIN_X and ly=DrawY-ORIGIN_Y, rom_address SHALL be ly*55+lx, computed by shift/subtract (ly<<6 - ly<<3 - ly), not by a multiplier; the maximum value 13584 fits in 14 bits.
REQ-028 Option band SHALL be 0 for ly 0-61, 1 for ly 62-123, 2 for ly 124-185, and 3 for ly 186-246, by comparison, with no divider.
REQ-029 overlay_en = menu_active & hit; highlight = overlay_en & (band==shown_sel); rom_address = 0 when there is no hit.
REQ-030 overlay_en, highlight and rom_address SHALL be registered, with exactly 1 cycle latency from DrawX/DrawY.

Reset
REQ-031 reset_n=0 SHALL asynchronously force: state IDLE, sel=0, shown_sel=0, menu_active=0, key edge registers=0, and all outputs 0.
REQ-032 Reset mid-session SHALL abandon the choice with no piece_valid pulse; the overlay drops at once.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the piece code enum (QUEEN, ROOK, BISHOP, KNIGHT), and band thresholds 62/124/186.
REQ-034 One sub-module, promo_addr_gen, SHALL contain the registered hit test, address and band logic; the FSM SHALL live in the top module.

Verification
REQ-035 Reset, then promo_req=1, frame_start -> busy=1; at DrawX=292, DrawY=116, the next cycle gives overlay_en=1, rom_address=0, highlight=1.
REQ-036 In SELECT, key_down x2 then frame_start -> pixel (300,250), i.e. ly=134 -> band 2 -> highlight=1, rom_address=134*55+8=7378.
REQ-037 key_up from sel=0 -> sel=3; key_enter -> piece_valid=1, piece_sel=3; piece_ready held 0 for 5 cycles keeps piece_valid=1 and piece_sel=3 stable; piece_ready=1 -> piece_valid=0 the next cycle.
REQ-038 key_up and key_down in the same cycle -> sel unchanged; key_enter together with key_down at sel=1 -> piece_sel=1.
REQ-039 After the handshake, overlay_en stays 1 until frame_start, then 0 with busy=0; pixel (291,116) and pixel (347,116) -> overlay_en=0 throughout.
REQ-040 reset_n=0 during COMMIT -> piece_valid=0 and overlay_en=0 immediately, with no result delivered.
